seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter SCAN_HZ, default 1000, meaning digit-slot rate in Hz; SLOT = CLK_HZ/SCAN_HZ cycles per slot.
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 500, meaning the anti-ghosting dead time at the start of each slot, with 1 <= BLANK_CYCLES < SLOT.
REQ-004 The block SHALL have parameter BLINK_DIV, default CLK_HZ/4, meaning cycles per blink phase, giving a 2 Hz blink.
REQ-005 The block SHALL have port clk, input, width 1, the clock.
REQ-006 The block SHALL have port rst, input, width 1, an asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, width 1, the display enable.
REQ-008 The block SHALL have ports digit0..digit3, input, width 4 each, the BCD digits (digit0 = seconds units ... digit3 = minutes tens).
REQ-009 The block SHALL have port dp_mask, input, width 4, where bit i lights the decimal point of digit i.
REQ-010 The block SHALL have port blink, input, width 1; 1 flashes the whole display (paused indication).
REQ-011 The block SHALL have port seg, output, width 7, the active-low segments, bit0 = a ... bit6 = g.
REQ-012 The block SHALL have port dp, output, width 1, the active-low decimal point.
REQ-013 The block SHALL have port an, output, width 4, the active-low digit enables, with an[i] driving digit i.
REQ-014 The block SHALL have port frame_done, output, width 1, a one-cycle pulse at the end of each 4-slot frame.

Function
REQ-015 Slot counter SHALL count 0..SLOT-1 and digit index SHALL advance 0->1->2->3->0 on each wrap.
REQ-016 Per-slot FSM SHALL have states BLANK (cycles 0..BLANK_CYCLES-1) and DRIVE (cycles BLANK_CYCLES..SLOT-1).
REQ-017 In BLANK, an SHALL be 4'b1111, seg 7'h7F and dp 1.
REQ-018 In DRIVE, exactly one an bit SHALL be low, for the current digit; seg SHALL show the snapshot decode and dp SHALL equal ~dp_mask[idx].
REQ-019 Snapshot registers SHALL load digit0..3 and dp_mask on the first BLANK cycle of slot 0 only; input changes elsewhere in a frame SHALL NOT affect that frame.
REQ-020 Decode SHALL map 0-9 to standard patterns (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10), and 10-15 SHALL blank as 7'h7F.
REQ-021 Outputs SHALL be registered, so seg/an/dp change on the same edge as the FSM state.
REQ-022 frame_done SHALL be 1 on the last cycle of slot 3 only.
REQ-023 The blink counter SHALL toggle blink_phase every BLINK_DIV cycles, free-running regardless of blink.
REQ-024 When blink=1 and blink_phase=1, an SHALL be forced to 4'b1111 while the scan continues; frame_done SHALL be unaffected.
REQ-025 When en=0, an SHALL be 4'b1111, seg 7'h7F and dp 1, and the slot counter and index SHALL be held at 0 in BLANK.
REQ-026 When en rises, scanning SHALL resume at slot 0 BLANK, cycle 0, with a snapshot load.
REQ-027 Counter widths SHALL be $clog2 of their maximum plus 1, with no overflow for default parameters.

Reset
REQ-028 While rst=1 (async assert), the outputs SHALL be an=4'hF, seg=7'h7F, dp=1 and frame_done=0.
REQ-029 While rst=1, the slot counter, index and blink counter SHALL be 0, blink_phase SHALL be 0, and snapshot digits SHALL be 4'hF (blank).
REQ-030 Reset mid-slot SHALL take effect immediately; after release, the first cycle SHALL be slot 0 BLANK.

Structure
REQ-031 A shared package seg_pkg SHALL hold the decode constants SEG_0..SEG_9, SEG_BLANK=7'h7F and AN_OFF=4'hF.
REQ-032 One sub-module, bcd_to_seg (combinational decode, 4->7 active-low), SHALL be instantiated once on the muxed snapshot digit.

Verification
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (SLOT=10), BLANK_CYCLES=2, BLINK_DIV=50.
REQ-033 With digits {3,2,1,0}={4,3,2,1} and en=1, the bench SHALL check that an cycles 1110, 1101, 1011, 0111, each low for 8 cycles after 2 blank cycles, with seg 79, 24, 30, 19 (hex) respectively, and frame_done every 40 cycles.
REQ-034 With digit0 changed 1->7 during slot 2, the bench SHALL check that the current frame still shows 79 and the next slot 0 shows 78.
REQ-035 With digit1=12 and dp_mask=0010, the bench SHALL check that slot 1 has seg=7F and dp=0, and other slots have dp=1.
REQ-036 With blink=1, the bench SHALL check that an=1111 during alternate 50-cycle windows, seg scanning continues, and frame_done keeps its 40-cycle period.
REQ-037 With rst pulsed at slot 2 cycle 5, the bench SHALL check an=F and seg=7F immediately; after release, 2 blank cycles, then an=1110 with a freshly loaded digit0.
REQ-038 With en=0 for 100 cycles, the bench SHALL check an=F and frame_done=0 throughout; after en=1, the first slot SHALL be digit0 after 2 blank cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment decode constants and slot state type
package seg_pkg;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All digit enables released (active-low)
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Per-slot phase: dead time first, then the digit is driven
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to active-low 7-segment decode
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Non-decimal codes blank the digit rather than showing hex glyphs
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with blanking and blink
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_DIV    = CLK_HZ / 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_mask,
    input  logic       blink,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int SLOT  = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(SLOT) + 1;
    localparam int BLK_W = $clog2(BLINK_DIV) + 1;

    slot_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       idx, idx_n;
    logic [BLK_W-1:0] bcnt, bcnt_n;
    logic             blink_phase, blink_phase_n;
    logic [15:0]      snap_dig, snap_dig_n;
    logic [3:0]       snap_dp, snap_dp_n;
    logic             load;
    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_n;
    logic             dp_n;
    logic [3:0]       an_n;
    logic             frame_done_n;

    // Slot counter, digit index and BLANK/DRIVE phase for the next cycle
    always_comb begin
        cnt_n   = cnt;
        idx_n   = idx;
        state_n = state;
        if (!en) begin
            cnt_n   = '0;
            idx_n   = 2'd0;
            state_n = ST_BLANK;
        end else if (cnt == CNT_W'(SLOT - 1)) begin
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
            state_n = ST_BLANK;
        end else begin
            cnt_n   = cnt + CNT_W'(1);
            state_n = (cnt_n >= CNT_W'(BLANK_CYCLES)) ? ST_DRIVE : ST_BLANK;
        end
    end

    // Free-running blink divider, independent of the blink request
    always_comb begin
        bcnt_n        = bcnt + BLK_W'(1);
        blink_phase_n = blink_phase;
        if (bcnt == BLK_W'(BLINK_DIV - 1)) begin
            bcnt_n        = '0;
            blink_phase_n = ~blink_phase;
        end
    end

    // Snapshot is taken once per frame so a frame never shows mixed time values
    always_comb begin
        load       = en && (state == ST_BLANK) && (cnt == '0) && (idx == 2'd0);
        snap_dig_n = load ? {digit3, digit2, digit1, digit0} : snap_dig;
        snap_dp_n  = load ? dp_mask : snap_dp;
    end

    // Select the snapshot digit for the slot being entered
    always_comb begin
        cur_digit = snap_dig_n[3:0];
        case (idx_n)
            2'd0: cur_digit = snap_dig_n[3:0];
            2'd1: cur_digit = snap_dig_n[7:4];
            2'd2: cur_digit = snap_dig_n[11:8];
            2'd3: cur_digit = snap_dig_n[15:12];
            default: cur_digit = snap_dig_n[3:0];
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Next output values, aligned with the next state so they register together
    always_comb begin
        seg_n        = SEG_BLANK;
        dp_n         = 1'b1;
        an_n         = AN_OFF;
        frame_done_n = en && (idx_n == 2'd3) && (cnt_n == CNT_W'(SLOT - 1));
        if (state_n == ST_DRIVE) begin
            seg_n = dec_seg;
            dp_n  = ~snap_dp_n[idx_n];
            an_n  = (blink && blink_phase_n) ? AN_OFF : ~(4'b0001 << idx_n);
        end
    end

    // State, counters, snapshot and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            idx         <= 2'd0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
            snap_dig    <= 16'hFFFF;
            snap_dp     <= 4'h0;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            an          <= AN_OFF;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            bcnt        <= bcnt_n;
            blink_phase <= blink_phase_n;
            snap_dig    <= snap_dig_n;
            snap_dp     <= snap_dp_n;
            seg         <= seg_n;
            dp          <= dp_n;
            an          <= an_n;
            frame_done  <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int CLK_HZ       = 1000;
    localparam int SCAN_HZ      = 100;
    localparam int BLANK_CYCLES = 2;
    localparam int BLINK_DIV    = 50;
    localparam int SLOT         = 10;
    localparam int FRAME        = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       blink = 1'b0;
    logic [3:0] digit0 = 4'd0;
    logic [3:0] digit1 = 4'd0;
    logic [3:0] digit2 = 4'd0;
    logic [3:0] digit3 = 4'd0;
    logic [3:0] dp_mask = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    int          n_tests = 0;
    int          n_fail = 0;
    int          gc = 0;
    int          sc = 0;
    int          fd_cnt = 0;
    logic [15:0] m_dig = 16'hFFFF;
    logic [3:0]  m_dpm = 4'h0;

    seg_scan_driver #(
        .CLK_HZ       (CLK_HZ),
        .SCAN_HZ      (SCAN_HZ),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dp_mask    (dp_mask),
        .blink      (blink),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare all outputs against the scan model for the current cycle
    task automatic verify();
        int         cyc;
        int         idx;
        int         phase;
        logic       drive;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       fd_e;
        logic [15:0] dig;
        logic [3:0]  dpm;
        cyc   = sc % SLOT;
        idx   = (sc / SLOT) % 4;
        phase = (gc / BLINK_DIV) % 2;
        dig   = m_dig;
        dpm   = m_dpm;
        drive = en && (cyc >= BLANK_CYCLES);
        an_e  = 4'hF;
        seg_e = 7'h7F;
        dp_e  = 1'b1;
        if (drive) begin
            seg_e = exp_dec(dig[idx*4 +: 4]);
            dp_e  = ~dpm[idx];
            if (!(blink && phase == 1))
                an_e = ~(4'b0001 << idx);
        end
        fd_e = en && ((sc % FRAME) == FRAME - 1);
        check($sformatf("an@s%0d", sc), {28'd0, an}, {28'd0, an_e});
        check($sformatf("seg@s%0d", sc), {25'd0, seg}, {25'd0, seg_e});
        check($sformatf("dp@s%0d", sc), {31'd0, dp}, {31'd0, dp_e});
        check($sformatf("fd@s%0d", sc), {31'd0, frame_done}, {31'd0, fd_e});
        if (frame_done) fd_cnt++;
    endtask

    // Advance one clock; the model snapshot follows the frame-start load
    task automatic step();
        if (en && (sc % FRAME) == 0) begin
            m_dig = {digit3, digit2, digit1, digit0};
            m_dpm = dp_mask;
        end
        @(posedge clk);
        @(negedge clk);
        gc++;
        if (en) sc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            verify();
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"}, {28'd0, an}, 32'hF);
        check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        check({tag, "_dp"}, {31'd0, dp}, 32'd1);
        check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        digit0 = 4'd1;
        digit1 = 4'd2;
        digit2 = 4'd3;
        digit3 = 4'd4;
        en     = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check_blank("reset");

        // Basic scan of 1,2,3,4
        rst = 1'b0;
        gc = 0; sc = 0; m_dig = 16'hFFFF; m_dpm = 4'h0;
        verify();
        fd_cnt = 0;
        run(80);
        check("fd_count_scan", fd_cnt, 2);

        // Input change mid-frame is deferred to the next frame
        run(25);
        digit0 = 4'd7;
        run(20);
        check("next_frame_seg", {25'd0, seg}, 32'h78);
        run(35);

        // Non-decimal digit blanks; decimal point follows the mask
        digit1  = 4'd12;
        dp_mask = 4'b0010;
        run(15);
        check("slot1_seg_blank", {25'd0, seg}, 32'h7F);
        check("slot1_dp_on", {31'd0, dp}, 32'd0);
        run(25);
        digit1  = 4'd2;
        dp_mask = 4'b0000;
        run(40);

        // Blink masks digit enables in alternate windows
        blink  = 1'b1;
        fd_cnt = 0;
        run(200);
        check("fd_count_blink", fd_cnt, 5);
        blink = 1'b0;

        // Reset mid-slot takes effect immediately
        run(25);
        digit0 = 4'd9;
        rst = 1'b1;
        #1;
        check_blank("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        gc = 0; sc = 0; m_dig = 16'hFFFF; m_dpm = 4'h0;
        verify();
        run(5);
        check("post_rst_an", {28'd0, an}, 32'hE);
        check("post_rst_seg", {25'd0, seg}, 32'h10);
        run(15);

        // Display disabled for 100 cycles, then restart at digit0
        run(15);
        en = 1'b0;
        sc = 0;
        fd_cnt = 0;
        run(100);
        check("fd_count_disabled", fd_cnt, 0);
        en = 1'b1;
        verify();
        run(5);
        check("en_resume_an", {28'd0, an}, 32'hE);
        check("en_resume_seg", {25'd0, seg}, 32'h10);
        run(35);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
